// File: rtl/simple_bus_arbiter.sv
// simple_bus_arbiter: round-robin arbiter that shares one simple_bus slave
// among NUM_REQ masters and forwards exactly one start/ready transaction per
// grant. Optional BUSY watchdog is enabled by defining SIMPLE_BUS_ARB_TIMEOUT_EN.
module simple_bus_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int MODE_W  = 2,
  parameter int TIMEOUT = 15
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          m_req,
  output logic [NUM_REQ-1:0]          m_gnt,
  input  logic [NUM_REQ-1:0]          m_start,
  input  logic [NUM_REQ*ADDR_W-1:0]   m_addr,
  input  logic [NUM_REQ*MODE_W-1:0]   m_mode,
  input  logic [NUM_REQ*DATA_W-1:0]   m_wdata,
  output logic [NUM_REQ-1:0]          m_rdy,
  output logic [DATA_W-1:0]           m_rdata,
  output logic                        m_err,
  output logic                        s_req,
  input  logic                        s_gnt,
  output logic                        s_start,
  output logic [ADDR_W-1:0]           s_addr,
  output logic [MODE_W-1:0]           s_mode,
  output logic [DATA_W-1:0]           s_wdata,
  input  logic                        s_rdy,
  input  logic [DATA_W-1:0]           s_rdata
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    GRANT = 2'd2,
    BUSY  = 2'd3
  } state_t;

  state_t             state, state_next;
  logic [IDX_W-1:0]   owner, owner_next, last, last_next, winner;
  logic               found;
  logic [NUM_REQ-1:0] owner_sel, owner_next_sel, gnt_next, rdy_next;
  logic [DATA_W-1:0]  rdata_next;
  logic               err_next, s_req_next, s_start_next;
  logic [ADDR_W-1:0]  addr_next;
  logic [MODE_W-1:0]  mode_next;
  logic [DATA_W-1:0]  wdata_next;
  logic               timeout_hit;

`ifdef SIMPLE_BUS_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] to_cnt;

  // Fires on the BUSY cycle whose increment would make the count reach TIMEOUT.
  assign timeout_hit = (state == BUSY) && (to_cnt == CNT_W'(TIMEOUT - 1));

  // Watchdog counter: zero outside BUSY, counts BUSY cycles without s_rdy.
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt <= {CNT_W{1'b0}};
    end else if (state != BUSY) begin
      to_cnt <= {CNT_W{1'b0}};
    end else if (!s_rdy) begin
      to_cnt <= to_cnt + CNT_W'(1);
    end else begin
      to_cnt <= to_cnt;
    end
  end
`else
  localparam int unused_timeout = TIMEOUT;
  assign timeout_hit = 1'b0;
`endif

  assign owner_sel      = ONE_HOT0 << owner;
  assign owner_next_sel = ONE_HOT0 << owner_next;

  // Round-robin search starting just after the last served master.
  always_comb begin
    winner = last;
    found  = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!found && m_req[IDX_W'((int'(last) + i) % NUM_REQ)]) begin
        winner = IDX_W'((int'(last) + i) % NUM_REQ);
        found  = 1'b1;
      end else begin
        winner = winner;
      end
    end
  end

  // Next-state and next-output decode for the transaction sequencer.
  always_comb begin
    state_next   = state;
    owner_next   = owner;
    last_next    = last;
    rdy_next     = {NUM_REQ{1'b0}};
    rdata_next   = m_rdata;
    err_next     = 1'b0;
    s_start_next = 1'b0;
    addr_next    = s_addr;
    mode_next    = s_mode;
    wdata_next   = s_wdata;
    case (state)
      IDLE: begin
        if (found) begin
          owner_next = winner;
          state_next = REQ;
        end else begin
          state_next = IDLE;
        end
      end
      REQ: begin
        // A withdrawn request abandons the attempt without moving priority.
        if (!m_req[owner]) begin
          state_next = IDLE;
        end else if (s_gnt) begin
          state_next = GRANT;
        end else begin
          state_next = REQ;
        end
      end
      GRANT: begin
        if (m_start[owner]) begin
          addr_next    = m_addr[int'(owner)*ADDR_W +: ADDR_W];
          mode_next    = m_mode[int'(owner)*MODE_W +: MODE_W];
          wdata_next   = m_wdata[int'(owner)*DATA_W +: DATA_W];
          s_start_next = 1'b1;
          state_next   = BUSY;
        end else if (!m_req[owner]) begin
          last_next  = owner;
          state_next = IDLE;
        end else begin
          state_next = GRANT;
        end
      end
      BUSY: begin
        // A real completion beats a watchdog expiry in the same cycle.
        if (s_rdy) begin
          rdy_next   = owner_sel;
          rdata_next = s_rdata;
          last_next  = owner;
          state_next = IDLE;
        end else if (timeout_hit) begin
          rdy_next   = owner_sel;
          err_next   = 1'b1;
          rdata_next = {DATA_W{1'b0}};
          last_next  = owner;
          state_next = IDLE;
        end else begin
          state_next = BUSY;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Grant/request decode; s_req lags REQ entry by one edge.
  always_comb begin
    if ((state_next == GRANT) || (state_next == BUSY)) begin
      gnt_next = owner_next_sel;
    end else begin
      gnt_next = {NUM_REQ{1'b0}};
    end
    s_req_next = (state != IDLE) && (state_next != IDLE);
  end

  // State, priority pointer and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      owner   <= {IDX_W{1'b0}};
      last    <= IDX_W'(NUM_REQ - 1);
      m_gnt   <= {NUM_REQ{1'b0}};
      m_rdy   <= {NUM_REQ{1'b0}};
      m_rdata <= {DATA_W{1'b0}};
      m_err   <= 1'b0;
      s_req   <= 1'b0;
      s_start <= 1'b0;
      s_addr  <= {ADDR_W{1'b0}};
      s_mode  <= {MODE_W{1'b0}};
      s_wdata <= {DATA_W{1'b0}};
    end else begin
      state   <= state_next;
      owner   <= owner_next;
      last    <= last_next;
      m_gnt   <= gnt_next;
      m_rdy   <= rdy_next;
      m_rdata <= rdata_next;
      m_err   <= err_next;
      s_req   <= s_req_next;
      s_start <= s_start_next;
      s_addr  <= addr_next;
      s_mode  <= mode_next;
      s_wdata <= wdata_next;
    end
  end

endmodule

// File: tb/tb_simple_bus_arbiter.sv
// tb_simple_bus_arbiter: table-driven arbitration vectors plus hand-written
// corner sequences; slave-side and master-side results go through scoreboards.
module tb_simple_bus_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  m_req;
  logic [3:0]  m_gnt;
  logic [3:0]  m_start;
  logic [31:0] m_addr;
  logic [7:0]  m_mode;
  logic [31:0] m_wdata;
  logic [3:0]  m_rdy;
  logic [7:0]  m_rdata;
  logic        m_err;
  logic        s_req;
  logic        s_gnt;
  logic        s_start;
  logic [7:0]  s_addr;
  logic [1:0]  s_mode;
  logic [7:0]  s_wdata;
  logic        s_rdy;
  logic [7:0]  s_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [3:0] mask;
    int         idx;
    logic [7:0] addr;
    logic [1:0] mode;
    logic [7:0] wdata;
    logic [7:0] rdata;
    int         delay;
  } vec_t;

  typedef struct {
    logic [7:0] addr;
    logic [1:0] mode;
    logic [7:0] wdata;
  } sexp_t;

  typedef struct {
    int         idx;
    logic [7:0] data;
    logic       err;
  } rexp_t;

  sexp_t s_exp[$];
  rexp_t r_exp[$];
  vec_t  vecs[9];

  logic       slave_en;
  int         slave_delay;
  logic [7:0] slave_data;
  int         cur_owner;

  simple_bus_arbiter dut (
    .clk(clk), .rst(rst),
    .m_req(m_req), .m_gnt(m_gnt), .m_start(m_start),
    .m_addr(m_addr), .m_mode(m_mode), .m_wdata(m_wdata),
    .m_rdy(m_rdy), .m_rdata(m_rdata), .m_err(m_err),
    .s_req(s_req), .s_gnt(s_gnt), .s_start(s_start),
    .s_addr(s_addr), .s_mode(s_mode), .s_wdata(s_wdata),
    .s_rdy(s_rdy), .s_rdata(s_rdata)
  );

  // Slave grants as soon as it sees a request.
  assign s_gnt = s_req;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_reset(input string p);
    chk($sformatf("%s_m_gnt", p),   32'(m_gnt),   32'h0);
    chk($sformatf("%s_m_rdy", p),   32'(m_rdy),   32'h0);
    chk($sformatf("%s_m_err", p),   32'(m_err),   32'h0);
    chk($sformatf("%s_m_rdata", p), 32'(m_rdata), 32'h0);
    chk($sformatf("%s_s_req", p),   32'(s_req),   32'h0);
    chk($sformatf("%s_s_start", p), 32'(s_start), 32'h0);
    chk($sformatf("%s_s_addr", p),  32'(s_addr),  32'h0);
    chk($sformatf("%s_s_mode", p),  32'(s_mode),  32'h0);
    chk($sformatf("%s_s_wdata", p), 32'(s_wdata), 32'h0);
  endtask

  task automatic wait_gnt(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (m_gnt == 4'b0000 && lat < 20);
  endtask

  task automatic wait_rdy(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (m_rdy == 4'b0000 && lat < 60);
  endtask

  // Owner issues its start pulse with random data on every other slice.
  task automatic do_start(input int idx, input logic [7:0] addr, input logic [1:0] mode,
                          input logic [7:0] wdata);
    m_addr  = $urandom;
    m_mode  = 8'($urandom);
    m_wdata = $urandom;
    m_addr[idx*8 +: 8]  = addr;
    m_mode[idx*2 +: 2]  = mode;
    m_wdata[idx*8 +: 8] = wdata;
    m_start = 4'(4'b0001 << idx);
    s_exp.push_back('{addr: addr, mode: mode, wdata: wdata});
    @(negedge clk);
    m_start = 4'b0000;
    chk("s_start_pulse", 32'(s_start), 32'h1);
  endtask

  task automatic run_vec(input vec_t v, input int n);
    int lat;
    m_req       = v.mask;
    slave_data  = v.rdata;
    slave_delay = v.delay;
    cur_owner   = v.idx;
    wait_gnt(lat);
    chk($sformatf("v%0d_gnt", n), 32'(m_gnt), 32'(4'(4'b0001 << v.idx)));
    chk($sformatf("v%0d_gnt_lat", n), 32'(lat), 32'd3);
    do_start(v.idx, v.addr, v.mode, v.wdata);
    wait_rdy(lat);
    chk($sformatf("v%0d_rdy_seen", n), 32'(lat < 60), 32'h1);
  endtask

  // Slave model: answers each s_start after slave_delay cycles.
  initial begin : slave
    s_rdy   = 1'b0;
    s_rdata = 8'h00;
    forever begin
      @(negedge clk);
      s_rdy = 1'b0;
      if (s_start === 1'b1 && slave_en) begin
        repeat (slave_delay) @(negedge clk);
        s_rdy   = 1'b1;
        s_rdata = slave_data;
        r_exp.push_back('{idx: cur_owner, data: slave_data, err: 1'b0});
      end
    end
  end

  // Monitor: pops scoreboards when the DUT produces a slave start or a completion.
  initial begin : monitor
    sexp_t se;
    rexp_t re;
    forever begin
      @(negedge clk);
      if (s_start === 1'b1) begin
        chk("s_start_expected", 32'(s_exp.size() > 0), 32'h1);
        if (s_exp.size() > 0) begin
          se = s_exp.pop_front();
          chk("s_addr", 32'(s_addr), 32'(se.addr));
          chk("s_mode", 32'(s_mode), 32'(se.mode));
          chk("s_wdata", 32'(s_wdata), 32'(se.wdata));
        end
      end
      if (m_rdy !== 4'b0000) begin
        chk("m_rdy_expected", 32'(r_exp.size() > 0), 32'h1);
        if (r_exp.size() > 0) begin
          re = r_exp.pop_front();
          chk("m_rdy_sel", 32'(m_rdy), 32'(4'(4'b0001 << re.idx)));
          chk("m_rdata", 32'(m_rdata), 32'(re.data));
          chk("m_err", 32'(m_err), 32'(re.err));
          chk("m_gnt_drop", 32'(m_gnt), 32'h0);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int   lat;
    int   seen;
    vec_t rv;
    rst = 1'b1; m_req = 4'b0000; m_start = 4'b0000;
    m_addr = 32'h0; m_mode = 8'h0; m_wdata = 32'h0;
    slave_en = 1'b1; slave_delay = 1; slave_data = 8'h00; cur_owner = 0;

    //          mask     idx addr   mode  wdata  rdata  delay
    vecs[0] = '{4'b0101, 0, 8'h12, 2'd1, 8'h34, 8'h56, 1};
    vecs[1] = '{4'b0101, 2, 8'h9A, 2'd3, 8'hBC, 8'hDE, 2};
    vecs[2] = '{4'b0101, 0, 8'h01, 2'd0, 8'hFF, 8'h00, 1};
    vecs[3] = '{4'b0101, 2, 8'hFE, 2'd2, 8'h00, 8'hFF, 4};
    vecs[4] = '{4'b0010, 1, 8'h3C, 2'd2, 8'h5A, 8'hA5, 3};
    vecs[5] = '{4'b1111, 2, 8'h44, 2'd1, 8'h11, 8'h22, 1};
    vecs[6] = '{4'b1001, 3, 8'h80, 2'd3, 8'h7F, 8'h81, 2};
    vecs[7] = '{4'b1111, 0, 8'h0F, 2'd0, 8'hF0, 8'h3C, 1};
    vecs[8] = '{4'b1000, 3, 8'h55, 2'd1, 8'hAA, 8'h66, 2};

    repeat (3) @(negedge clk);
    chk_reset("init");
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      run_vec(vecs[i], i);
    end

    // Withdrawal in GRANT: grant falls, no start, master 0 wins next.
    m_req = 4'b1000;
    wait_gnt(lat);
    chk("wd_gnt", 32'(m_gnt), 32'h8);
    m_req = 4'b0001;
    @(negedge clk);
    chk("wd_gnt_drop", 32'(m_gnt), 32'h0);
    chk("wd_no_start", 32'(s_start), 32'h0);
    rv = '{4'b0001, 0, 8'h5A, 2'd3, 8'hC0, 8'h3D, 2};
    run_vec(rv, 9);

    // Stray starts from a non-owner during GRANT and during BUSY.
    m_req = 4'b0010;
    cur_owner = 1; slave_data = 8'hC7; slave_delay = 5;
    wait_gnt(lat);
    chk("stray_gnt", 32'(m_gnt), 32'h2);
    m_addr[16 +: 8] = 8'h77;
    m_start = 4'b0100;
    @(negedge clk);
    m_start = 4'b0000;
    chk("stray_grant_no_start", 32'(s_start), 32'h0);
    chk("stray_grant_gnt_held", 32'(m_gnt), 32'h2);
    do_start(1, 8'h11, 2'd2, 8'h22);
    @(negedge clk);
    m_addr[16 +: 8] = 8'h99;
    m_addr[8 +: 8]  = 8'h55;
    m_start = 4'b0100;
    @(negedge clk);
    m_start = 4'b0000;
    chk("stray_busy_no_start", 32'(s_start), 32'h0);
    chk("stray_busy_addr", 32'(s_addr), 32'h11);
    chk("stray_busy_mode", 32'(s_mode), 32'h2);
    wait_rdy(lat);
    chk("stray_rdy_seen", 32'(lat < 60), 32'h1);

    // Reset during BUSY: outputs clear, no completion, master 0 first again.
    slave_en = 1'b0;
    m_req = 4'b0100;
    wait_gnt(lat);
    chk("rst_gnt", 32'(m_gnt), 32'h4);
    do_start(2, 8'hA0, 2'd3, 8'h0B);
    @(negedge clk);
    rst = 1'b1;
    m_req = 4'b0000;
    @(negedge clk);
    rst = 1'b0;
    chk_reset("midrst");
    seen = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (m_rdy !== 4'b0000) seen++;
    end
    chk("midrst_no_rdy", 32'(seen), 32'h0);
    slave_en = 1'b1;
    rv = '{4'b1111, 0, 8'hE1, 2'd2, 8'h1E, 8'h99, 1};
    run_vec(rv, 10);

    // Slave never answers.
    slave_en = 1'b0;
    m_req = 4'b0010;
    wait_gnt(lat);
    chk("to_gnt", 32'(m_gnt), 32'h2);
`ifdef SIMPLE_BUS_ARB_TIMEOUT_EN
    r_exp.push_back('{idx: 1, data: 8'h00, err: 1'b1});
`endif
    do_start(1, 8'hC3, 2'd1, 8'h3E);
`ifdef SIMPLE_BUS_ARB_TIMEOUT_EN
    wait_rdy(lat);
    chk("to_latency", 32'(lat), 32'd15);
    m_req = 4'b0000;
    @(negedge clk);
    chk("to_err_one_cycle", 32'(m_err), 32'h0);
    chk("to_rdy_one_cycle", 32'(m_rdy), 32'h0);
    repeat (4) @(negedge clk);
`else
    seen = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (m_rdy !== 4'b0000 || m_err !== 1'b0) seen++;
    end
    chk("busy_hold_no_rdy", 32'(seen), 32'h0);
    chk("busy_hold_gnt", 32'(m_gnt), 32'h2);
    chk("busy_hold_s_req", 32'(s_req), 32'h1);
    m_req = 4'b0000;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_reset("end");
`endif

    chk("s_queue_empty", 32'(s_exp.size()), 32'h0);
    chk("r_queue_empty", 32'(r_exp.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/simple_bus_arbiter.md
# simple_bus_arbiter

Round-robin arbiter and transaction sequencer that shares one `simple_bus` memory-side slave among `NUM_REQ` CPU-side masters. It sits between the CPU modules and the memory module in `top`. It selects one requester, obtains the slave grant, forwards a single start/ready transaction, and returns the result to the owner before arbitrating again.

## Interface
- `NUM_REQ`, 4: number of master ports; must be ≥2.
- `ADDR_W`, 8: address width.
- `DATA_W`, 8: data width.
- `MODE_W`, 2: mode width.
- `TIMEOUT`, 15: watchdog limit in cycles; only used with the timeout feature.
- `clk`  in  1: single clock; all logic is on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `m_req`  in  NUM_REQ: per-master request, level.
- `m_gnt`  out  NUM_REQ: per-master grant, one-hot or zero.
- `m_start`  in  NUM_REQ: per-master start pulse, valid only while granted.
- `m_addr`  in  NUM_REQ*ADDR_W: packed addresses; master i occupies slice i.
- `m_mode`  in  NUM_REQ*MODE_W: packed modes.
- `m_wdata`  in  NUM_REQ*DATA_W: packed write data.
- `m_rdy`  out  NUM_REQ: per-master completion pulse.
- `m_rdata`  out  DATA_W: read data, broadcast to all masters, valid with `m_rdy`.
- `m_err`  out  1: abort pulse, coincident with `m_rdy`.
- `s_req`  out  1: request to the slave.
- `s_gnt`  in  1: grant from the slave.
- `s_start`  out  1: start pulse to the slave.
- `s_addr`  out  ADDR_W: address to the slave.
- `s_mode`  out  MODE_W: mode to the slave.
- `s_wdata`  out  DATA_W: write data to the slave.
- `s_rdy`  in  1: slave completion.
- `s_rdata`  in  DATA_W: read data from the slave.

## Operation
- FSM states: IDLE, REQ, GRANT, BUSY.
- IDLE:
  - If any `m_req` is set, select the winner round-robin. The search starts at index `last+1` and wraps modulo `NUM_REQ`.
  - Register the winner in `owner` and go to REQ.
  - `last` resets to `NUM_REQ-1`, so master 0 has first priority after reset.
- REQ:
  - `s_req`=1.
  - If `s_gnt`=1, go to GRANT.
  - If `m_req[owner]` drops first, go to IDLE without updating `last`.
- GRANT:
  - `m_gnt[owner]`=1 and `s_req`=1.
  - On `m_start[owner]`: latch that master's addr/mode/wdata slices into `s_addr`/`s_mode`/`s_wdata`, assert `s_start` for one cycle, and go to BUSY.
  - If `m_req[owner]` drops before start, release the grant, set `last`=`owner`, and go to IDLE.
- BUSY:
  - `m_gnt[owner]` and `s_req` stay high.
  - On `s_rdy`: capture `s_rdata` into `m_rdata`, pulse `m_rdy[owner]` for one cycle, set `last`=`owner`, and go to IDLE.
- Exactly one transaction is performed per grant. A master must re-win arbitration for each further transaction.
- `m_start` from any non-owner, or from the owner outside GRANT, is ignored.
- If `m_start` and `s_rdy` arrive in the same cycle, `s_rdy` is ignored unless the state is BUSY.
- Reset mid-transaction:
  - State returns to IDLE and all outputs return to reset values on the next edge.
  - No `m_rdy` is issued for the aborted transfer.
- Reset values:
  - `m_gnt`=0, `m_rdy`=0, `m_err`=0, `m_rdata`=0.
  - `s_req`=0, `s_start`=0, `s_addr`=0, `s_mode`=0, `s_wdata`=0.
- All outputs are registered.

## Timing
- Latency from `m_req` high in IDLE to `s_req` high: 2 edges (IDLE→REQ, then `s_req` registered).
- Latency from `s_gnt` high to `m_gnt[owner]` high: 1 cycle.
- Latency from `m_start` to `s_start` high: 1 cycle. `s_addr`, `s_mode` and `s_wdata` are valid in that same cycle and held until the next `m_start`.
- Latency from `s_rdy` to `m_rdy[owner]` and `m_rdata`: 1 cycle.
- `m_gnt` falls in the same cycle as `m_rdy`.
- Minimum gap between two grants: 1 IDLE cycle.

## Configuration
- Macro: `SIMPLE_BUS_ARB_TIMEOUT_EN`.
- With the macro defined:
  - A counter of width `$clog2(TIMEOUT+1)` clears on BUSY entry and increments each BUSY cycle without `s_rdy`.
  - When the count reaches `TIMEOUT`, pulse `m_rdy[owner]` and `m_err` for one cycle, set `m_rdata`=0, set `last`=`owner`, and go to IDLE.
  - If `s_rdy` arrives on the timeout cycle, it wins: normal completion, `m_err`=0.
- Without the macro:
  - BUSY waits indefinitely for `s_rdy`.
  - `m_err` is tied to 0 and no counter is generated.

## Test plan
- **Single master:** reset, then master 1 holds `m_req`; slave grants immediately; master pulses `m_start` with addr=0x3C, mode=2; slave returns `s_rdy` with rdata=0xA5 after 3 cycles → `s_start` seen with addr 0x3C and mode 2; `m_rdy[1]` pulses one cycle with `m_rdata`=0xA5; `m_gnt[1]` drops.
- **Round-robin fairness:** masters 0 and 2 hold `m_req` continuously for 4 transactions → grant order 0, 2, 0, 2; never two consecutive grants to the same master.
- **Withdrawal:** master 3 drops `m_req` while in GRANT before `m_start` → `m_gnt[3]` falls next cycle; no `s_start`; next grant goes to master 0 if it is requesting.
- **Reset mid-BUSY:** assert `rst` for 1 cycle → all outputs are 0 on the next cycle; no `m_rdy` pulse; the next grant goes to master 0.
- **Stray starts:** a non-owner pulses `m_start` during GRANT and during BUSY → no effect on `s_start` or `s_addr`.
- **Timeout (with `SIMPLE_BUS_ARB_TIMEOUT_EN`, TIMEOUT=15):** slave never asserts `s_rdy` → `m_rdy[owner]` and `m_err` pulse exactly 15 cycles after BUSY entry, with `m_rdata`=0. Without the macro, the arbiter stays in BUSY for 100 cycles and `m_err` stays 0.
